// File: rtl/pe_mac_os.sv
// Output-stationary systolic PE: MACs west activations with north weights into a local
// accumulator, forwards operands east/south, and drains results through a valid/ready register.
module pe_mac_os #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int SIGNED = 1,
    parameter int SAT    = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_in,
    input  logic              w_valid,
    input  logic [DATA_W-1:0] w_in,
    output logic              a_valid_o,
    output logic [DATA_W-1:0] a_out,
    output logic              w_valid_o,
    output logic [DATA_W-1:0] w_out,
    input  logic              drain,
    output logic              drain_rdy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_ovf
);

    localparam int PROD_W = 2 * DATA_W;
    localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic               a_valid_q, w_valid_q;
    logic [DATA_W-1:0]  a_q, w_q;

    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               out_ovf_q, out_ovf_d;

    logic               fire;
    logic               restart;
    logic [PROD_W-1:0]  a_ext, w_ext, prod;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   add_base;
    logic [ACC_W:0]     sum_full;
    logic               add_ovf;
    logic [ACC_W-1:0]   sat_val;
    logic [ACC_W-1:0]   acc_new;
    logic [CNT_W-1:0]   cnt_inc;

    assign fire      = a_valid & w_valid;
    assign drain_rdy = drain & (~out_valid_q | out_ready);

    // A fresh accumulation starts from zero either when empty or when this cycle's drain
    // takes the old value away, so a coincident product is counted exactly once.
    assign restart  = drain_rdy | (state_q == ST_EMPTY);
    assign add_base = restart ? '0 : acc_q;
    assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        if (SIGNED != 0) begin
            a_ext    = PROD_W'($signed(a_in));
            w_ext    = PROD_W'($signed(w_in));
            prod     = a_ext * w_ext;
            prod_ext = ACC_W'($signed(prod));
        end else begin
            a_ext    = PROD_W'(a_in);
            w_ext    = PROD_W'(w_in);
            prod     = a_ext * w_ext;
            prod_ext = ACC_W'(prod);
        end
    end

    always_comb begin
        sum_full = {1'b0, add_base} + {1'b0, prod_ext};
        if (SIGNED != 0) begin
            add_ovf = (add_base[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum_full[ACC_W-1] != add_base[ACC_W-1]);
            sat_val = add_base[ACC_W-1] ? S_MIN : S_MAX;
        end else begin
            add_ovf = sum_full[ACC_W];
            sat_val = {ACC_W{1'b1}};
        end
        acc_new = ((SAT != 0) && add_ovf) ? sat_val : sum_full[ACC_W-1:0];
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves one
        // unassigned; a missing default here would infer a latch.
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q & ~out_ready;
        out_data_d  = out_data_q;
        out_cnt_d   = out_cnt_q;
        out_ovf_d   = out_ovf_q;

        if (drain_rdy) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_q;
            out_cnt_d   = cnt_q;
            out_ovf_d   = ovf_q;
            state_d     = ST_EMPTY;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
        end

        if (fire) begin
            state_d = ST_ACCUM;
            acc_d   = acc_new;
            cnt_d   = restart ? CNT_W'(1) : cnt_inc;
            ovf_d   = (restart ? 1'b0 : ovf_q) | add_ovf;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_EMPTY;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            a_valid_q   <= 1'b0;
            w_valid_q   <= 1'b0;
            a_q         <= '0;
            w_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_cnt_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            a_valid_q   <= a_valid;
            w_valid_q   <= w_valid;
            if (a_valid) a_q <= a_in;
            if (w_valid) w_q <= w_in;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_cnt_q   <= out_cnt_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign a_valid_o = a_valid_q;
    assign a_out     = a_q;
    assign w_valid_o = w_valid_q;
    assign w_out     = w_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_cnt   = out_cnt_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_pe_mac_os.sv
// Bench for pe_mac_os: four parameterisations share one stimulus stream; drained results
// are predicted into a scoreboard queue and compared when the selected instance presents them.
module tb_pe_mac_os;

    logic       clk;
    logic       rstn;
    logic       a_valid, w_valid, drain, out_ready;
    logic [7:0] a_in, w_in;

    // inst 0: signed, 24-bit, saturating (defaults)
    logic        a_valid_o_s, w_valid_o_s, drain_rdy_s, out_valid_s, out_ovf_s;
    logic [7:0]  a_out_s, w_out_s, out_cnt_s;
    logic [23:0] out_data_s;
    // inst 1: unsigned, 24-bit
    logic        a_valid_o_u, w_valid_o_u, drain_rdy_u, out_valid_u, out_ovf_u;
    logic [7:0]  a_out_u, w_out_u, out_cnt_u;
    logic [23:0] out_data_u;
    // inst 2: signed, 16-bit, saturating
    logic        a_valid_o_p, w_valid_o_p, drain_rdy_p, out_valid_p, out_ovf_p;
    logic [7:0]  a_out_p, w_out_p, out_cnt_p;
    logic [15:0] out_data_p;
    // inst 3: signed, 16-bit, wrapping
    logic        a_valid_o_w, w_valid_o_w, drain_rdy_w, out_valid_w, out_ovf_w;
    logic [7:0]  a_out_w, w_out_w, out_cnt_w;
    logic [15:0] out_data_w;

    pe_mac_os u_dut_s (
        .clk(clk), .rstn(rstn), .a_valid(a_valid), .a_in(a_in), .w_valid(w_valid), .w_in(w_in),
        .a_valid_o(a_valid_o_s), .a_out(a_out_s), .w_valid_o(w_valid_o_s), .w_out(w_out_s),
        .drain(drain), .drain_rdy(drain_rdy_s), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .out_cnt(out_cnt_s), .out_ovf(out_ovf_s)
    );

    pe_mac_os #(.SIGNED(0)) u_dut_u (
        .clk(clk), .rstn(rstn), .a_valid(a_valid), .a_in(a_in), .w_valid(w_valid), .w_in(w_in),
        .a_valid_o(a_valid_o_u), .a_out(a_out_u), .w_valid_o(w_valid_o_u), .w_out(w_out_u),
        .drain(drain), .drain_rdy(drain_rdy_u), .out_valid(out_valid_u), .out_ready(out_ready),
        .out_data(out_data_u), .out_cnt(out_cnt_u), .out_ovf(out_ovf_u)
    );

    pe_mac_os #(.ACC_W(16), .SAT(1)) u_dut_p (
        .clk(clk), .rstn(rstn), .a_valid(a_valid), .a_in(a_in), .w_valid(w_valid), .w_in(w_in),
        .a_valid_o(a_valid_o_p), .a_out(a_out_p), .w_valid_o(w_valid_o_p), .w_out(w_out_p),
        .drain(drain), .drain_rdy(drain_rdy_p), .out_valid(out_valid_p), .out_ready(out_ready),
        .out_data(out_data_p), .out_cnt(out_cnt_p), .out_ovf(out_ovf_p)
    );

    pe_mac_os #(.ACC_W(16), .SAT(0)) u_dut_w (
        .clk(clk), .rstn(rstn), .a_valid(a_valid), .a_in(a_in), .w_valid(w_valid), .w_in(w_in),
        .a_valid_o(a_valid_o_w), .a_out(a_out_w), .w_valid_o(w_valid_o_w), .w_out(w_out_w),
        .drain(drain), .drain_rdy(drain_rdy_w), .out_valid(out_valid_w), .out_ready(out_ready),
        .out_data(out_data_w), .out_cnt(out_cnt_w), .out_ovf(out_ovf_w)
    );

    typedef struct {
        string       tag;
        int          inst;
        logic [31:0] data;
        logic [31:0] cnt;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic obs_valid(input int inst);
        case (inst)
            0:       return out_valid_s;
            1:       return out_valid_u;
            2:       return out_valid_p;
            default: return out_valid_w;
        endcase
    endfunction

    function automatic logic obs_rdy(input int inst);
        case (inst)
            0:       return drain_rdy_s;
            1:       return drain_rdy_u;
            2:       return drain_rdy_p;
            default: return drain_rdy_w;
        endcase
    endfunction

    function automatic logic [31:0] obs_data(input int inst);
        case (inst)
            0:       return 32'($signed(out_data_s));
            1:       return 32'(out_data_u);
            2:       return 32'($signed(out_data_p));
            default: return 32'($signed(out_data_w));
        endcase
    endfunction

    function automatic logic [31:0] obs_cnt(input int inst);
        case (inst)
            0:       return 32'(out_cnt_s);
            1:       return 32'(out_cnt_u);
            2:       return 32'(out_cnt_p);
            default: return 32'(out_cnt_w);
        endcase
    endfunction

    function automatic logic obs_ovf(input int inst);
        case (inst)
            0:       return out_ovf_s;
            1:       return out_ovf_u;
            2:       return out_ovf_p;
            default: return out_ovf_w;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, $signed(obs), obs,
                   $signed(exp), exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mac(input int a, input int w);
        a_valid = 1'b1;
        w_valid = 1'b1;
        a_in    = 8'(a);
        w_in    = 8'(w);
        tick();
        a_valid = 1'b0;
        w_valid = 1'b0;
    endtask

    task automatic push_exp(input string tag, input int inst, input int data, input int cnt,
                            input logic ovf);
        exp_t e;
        e.tag  = tag;
        e.inst = inst;
        e.data = 32'(data);
        e.cnt  = 32'(cnt);
        e.ovf  = ovf;
        sb_q.push_back(e);
    endtask

    task automatic drain_pulse(input string tag, input int inst);
        drain = 1'b1;
        #1;
        check({tag, "_rdy"}, 32'(obs_rdy(inst)), 32'd1);
        tick();
        drain = 1'b0;
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            for (int i = 0; i < 8; i++) begin
                if (obs_valid(e.inst) === 1'b1) break;
                tick();
            end
            check({e.tag, "_valid"}, 32'(obs_valid(e.inst)), 32'd1);
            check({e.tag, "_data"},  obs_data(e.inst),       e.data);
            check({e.tag, "_cnt"},   obs_cnt(e.inst),        e.cnt);
            check({e.tag, "_ovf"},   32'(obs_ovf(e.inst)),   32'(e.ovf));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn      = 1'b0;
        a_valid   = 1'b0;
        w_valid   = 1'b0;
        a_in      = '0;
        w_in      = '0;
        drain     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid_s), 32'd0);
        check("rst_out_data",  obs_data(0),      32'd0);
        check("rst_a_valid_o", 32'(a_valid_o_s), 32'd0);
        rstn = 1'b1;
        tick();

        // Reset mid-accumulation with a full output register
        out_ready = 1'b0;
        mac(2, 3);
        mac(4, 5);
        drain_pulse("t1_pre", 0);
        check("t1_full_valid", 32'(out_valid_s), 32'd1);
        check("t1_full_data",  obs_data(0),      32'd26);
        a_valid = 1'b1;
        w_valid = 1'b1;
        a_in    = 8'd7;
        w_in    = 8'd7;
        tick();
        #2;
        rstn = 1'b0;
        #1;
        check("t1_rst_out_valid", 32'(out_valid_s), 32'd0);
        check("t1_rst_out_data",  obs_data(0),      32'd0);
        check("t1_rst_out_cnt",   obs_cnt(0),       32'd0);
        check("t1_rst_a_out",     32'(a_out_s),     32'd0);
        check("t1_rst_a_valid_o", 32'(a_valid_o_s), 32'd0);
        check("t1_rst_w_valid_o", 32'(w_valid_o_s), 32'd0);
        a_valid = 1'b0;
        w_valid = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        out_ready = 1'b1;
        push_exp("t1_post", 0, 0, 0, 1'b0);
        drain_pulse("t1_post", 0);
        pop_check();

        // Unsigned ramp with operand forwarding
        for (int w = 0; w < 16; w++) begin
            mac(1, w);
            check($sformatf("t2_a_out_%0d", w),     32'(a_out_u),     32'd1);
            check($sformatf("t2_w_out_%0d", w),     32'(w_out_u),     32'(w));
            check($sformatf("t2_w_valid_o_%0d", w), 32'(w_valid_o_u), 32'd1);
        end
        a_in = 8'hAA;
        w_in = 8'h55;
        tick();
        check("t2_a_valid_o_low", 32'(a_valid_o_u), 32'd0);
        check("t2_a_out_hold",    32'(a_out_u),     32'd1);
        check("t2_w_out_hold",    32'(w_out_u),     32'd15);
        push_exp("t2", 1, 120, 16, 1'b0);
        drain_pulse("t2", 1);
        pop_check();

        // Signed products
        mac(-3, 5);
        mac(7, -2);
        mac(-4, -4);
        push_exp("t3", 0, -13, 3, 1'b0);
        drain_pulse("t3", 0);
        pop_check();

        // 16-bit overflow: saturating and wrapping instances
        mac(127, 127);
        mac(127, 127);
        mac(127, 127);
        push_exp("t4_sat",  2, 32767,  3, 1'b1);
        push_exp("t4_wrap", 3, -17149, 3, 1'b1);
        drain_pulse("t4", 2);
        pop_check();
        pop_check();

        // Drain coincident with a fire
        mac(2, 5);
        push_exp("t5a", 0, 10, 1, 1'b0);
        drain   = 1'b1;
        a_valid = 1'b1;
        w_valid = 1'b1;
        a_in    = 8'd2;
        w_in    = 8'd3;
        #1;
        check("t5a_rdy", 32'(drain_rdy_s), 32'd1);
        tick();
        drain   = 1'b0;
        a_valid = 1'b0;
        w_valid = 1'b0;
        pop_check();
        push_exp("t5b", 0, 6, 1, 1'b0);
        drain_pulse("t5b", 0);
        pop_check();

        // Backpressure: held drain waits for the consumer
        tick();
        out_ready = 1'b0;
        mac(5, 1);
        push_exp("t6a", 0, 5, 1, 1'b0);
        drain_pulse("t6a", 0);
        drain = 1'b1;
        #1;
        check("t6_held_rdy", 32'(drain_rdy_s), 32'd0);
        a_valid = 1'b1;
        w_valid = 1'b1;
        a_in    = 8'd2;
        w_in    = 8'd2;
        tick();
        a_valid = 1'b0;
        w_valid = 1'b0;
        check("t6_stable_valid", 32'(out_valid_s), 32'd1);
        check("t6_stable_data",  obs_data(0),      32'd5);
        check("t6_still_rdy",    32'(drain_rdy_s), 32'd0);
        push_exp("t6b", 0, 4, 1, 1'b0);
        out_ready = 1'b1;
        #1;
        check("t6_release_rdy", 32'(drain_rdy_s), 32'd1);
        pop_check();
        tick();
        drain = 1'b0;
        pop_check();
        tick();
        check("t6_empty_after", 32'(out_valid_s), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
